// File: rtl/edge_event_packer.sv
// Packs edge strobes into {kind, delta, sample} records behind a show-ahead FIFO.
// Optional drop counter output enabled by defining EDGE_EVENT_DROP_CNT_EN.
module edge_event_packer #(
  parameter int N     = 16,
  parameter int T     = 12,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [N-1:0]             edges,
  input  logic [N-1:0]             data_in,
  input  logic                     start,
  input  logic                     stop,
  output logic                     running,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [2+T+N-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef EDGE_EVENT_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 2 + T + N;
  localparam logic [T-1:0]  MAX  = '1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  localparam logic [1:0] K_EDGE  = 2'b00;
  localparam logic [1:0] K_TMO   = 2'b01;
  localparam logic [1:0] K_START = 2'b10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic            running_q, running_d;
  logic [T-1:0]    cnt_q, cnt_d;
  logic [T-1:0]    nxt;
  logic            push;
  logic            ovf_clr;
  logic [RW-1:0]   prec;

  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [RW-1:0]   head_q, head_d;
  logic            ovf_q, ovf_d;
  logic            pop, full, wr, drop;

  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    ovf_clr   = 1'b0;
    prec      = {K_EDGE, nxt, data_in};
    nxt       = cnt_q + T'(1);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          running_d = 1'b1;
          cnt_d     = '0;
          ovf_clr   = 1'b1;
          push      = 1'b1;
          prec      = {K_START, {T{1'b0}}, data_in};
        end
      end
      RUN: begin
        if (stop) begin
          state_d   = IDLE;
          running_d = 1'b0;
        end else if (en) begin
          // An edge always wins over a timeout on the same strobe.
          if (|edges) begin
            push  = 1'b1;
            prec  = {K_EDGE, nxt, data_in};
            cnt_d = '0;
          end else if (nxt == MAX) begin
            push  = 1'b1;
            prec  = {K_TMO, MAX, data_in};
            cnt_d = '0;
          end else begin
            cnt_d = nxt;
          end
        end
      end
    endcase
  end

  assign pop  = (level_q != '0) && rd_ready;
  assign full = (level_q == FULL);
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (wr && !pop)
      level_d = level_q + LW'(1);
    else if (!wr && pop)
      level_d = level_q - LW'(1);
    ovf_d  = ovf_clr ? drop : (ovf_q | drop);
    head_d = head_q;
    // New head is the incoming record when nothing older survives the edge.
    if (wr && (level_q == LW'(pop)))
      head_d = prec;
    else if (level_d != '0)
      head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr_q] <= prec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      head_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      head_q    <= head_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef EDGE_EVENT_DROP_CNT_EN
  logic [15:0] dcnt_q, dcnt_d;

  always_comb begin
    dcnt_d = dcnt_q;
    if (ovf_clr)
      dcnt_d = {15'd0, drop};
    else if (drop && (dcnt_q != 16'hFFFF))
      dcnt_d = dcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      dcnt_q <= '0;
    else
      dcnt_q <= dcnt_d;
  end

  assign drop_cnt = dcnt_q;
`endif

  assign running  = running_q;
  assign rd_valid = (level_q != '0);
  assign rd_data  = head_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_event_packer.sv
// Scoreboard bench for edge_event_packer built with T=4, DEPTH=4.
// Stimulus pushes expected records; a negedge monitor pops on each handshake.
module tb_edge_event_packer;

  localparam int N     = 16;
  localparam int T     = 4;
  localparam int DEPTH = 4;
  localparam int RW    = 2 + T + N;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [N-1:0]  edges;
  logic [N-1:0]  data_in;
  logic          start;
  logic          stop;
  logic          running;
  logic          rd_valid;
  logic          rd_ready;
  logic [RW-1:0] rd_data;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef EDGE_EVENT_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] expq [$];

  edge_event_packer #(.N(N), .T(T), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .edges    (edges),
    .data_in  (data_in),
    .start    (start),
    .stop     (stop),
    .running  (running),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .overflow (overflow)
`ifdef EDGE_EVENT_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] rec(input logic [1:0] k,
                                        input logic [T-1:0] d,
                                        input logic [N-1:0] s);
    return {k, d, s};
  endfunction

  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (!reset && rd_valid && rd_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL sb_extra got %h expected none", rd_data);
      end else begin
        e = expq.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL sb_record got %h expected %h", rd_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic [N-1:0] ed,
                     input logic [N-1:0] d, input logic s = 1'b0,
                     input logic p = 1'b0);
    en = e; edges = ed; data_in = d; start = s; stop = p;
    @(posedge clk);
    #1;
    en = 1'b0; edges = '0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!rd_valid) break;
      @(posedge clk);
      #1;
    end
    rd_ready = 1'b0;
    chk("drain_empty", {31'd0, rd_valid}, 32'd0);
    chk("drain_sb", expq.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; edges = '0; data_in = '0;
    start = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_run", {31'd0, running}, 32'd0);
    chk("rst_data", {10'd0, rd_data}, 32'd0);

    // edges in IDLE are ignored
    cyc(1'b1, 16'hFFFF, 16'h1111);
    chk("idle_level", {29'd0, level}, 32'd0);

    // start record
    expq.push_back(rec(2'b10, 4'd0, 16'h00A5));
    cyc(1'b0, '0, 16'h00A5, 1'b1);
    chk("start_valid", {31'd0, rd_valid}, 32'd1);
    chk("start_data", {10'd0, rd_data}, {10'd0, rec(2'b10, 4'd0, 16'h00A5)});
    chk("start_level", {29'd0, level}, 32'd1);
    chk("start_run", {31'd0, running}, 32'd1);
    drain();

    // strobes 1..5, with an en=0 gap
    cyc(1'b1, '0, 16'h0001);
    cyc(1'b0, 16'hFFFF, 16'h0002);
    cyc(1'b1, '0, 16'h0002);
    expq.push_back(rec(2'b00, 4'd3, 16'h3333));
    cyc(1'b1, 16'h0001, 16'h3333);
    expq.push_back(rec(2'b00, 4'd1, 16'h4444));
    cyc(1'b1, 16'h8000, 16'h4444);
    cyc(1'b1, '0, 16'h5555);
    chk("strobe_level", {29'd0, level}, 32'd2);
    drain();

    // restart, then timeout and edge at MAX
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("stop_run", {31'd0, running}, 32'd0);
    expq.push_back(rec(2'b10, 4'd0, 16'h0BEE));
    cyc(1'b0, '0, 16'h0BEE, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) expq.push_back(rec(2'b01, 4'd15, 16'h0100 + 16'(i)));
      cyc(1'b1, '0, 16'h0100 + 16'(i));
    end
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) expq.push_back(rec(2'b00, 4'd15, 16'h0200 + 16'(i)));
      cyc(1'b1, (i == 15) ? 16'h0004 : 16'h0000, 16'h0200 + 16'(i));
    end
    chk("tmo_level", {29'd0, level}, 32'd3);
    drain();

    // fill to full and overflow
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    expq.push_back(rec(2'b10, 4'd0, 16'h5000));
    cyc(1'b0, '0, 16'h5000, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      expq.push_back(rec(2'b00, 4'd1, 16'h5000 + 16'(i)));
      cyc(1'b1, 16'h0010, 16'h5000 + 16'(i));
    end
    chk("full_level", {29'd0, level}, 32'd4);
    chk("full_ovf0", {31'd0, overflow}, 32'd0);
    cyc(1'b1, 16'h0010, 16'h5004);
    chk("drop_level", {29'd0, level}, 32'd4);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
`ifdef EDGE_EVENT_DROP_CNT_EN
    chk("drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif
    rd_ready = 1'b1;
    expq.push_back(rec(2'b00, 4'd1, 16'h5005));
    cyc(1'b1, 16'h0100, 16'h5005);
    rd_ready = 1'b0;
    chk("fullpop_level", {29'd0, level}, 32'd4);
    chk("fullpop_ovf", {31'd0, overflow}, 32'd1);
    drain();

    // start+stop in RUN
    expq.push_back(rec(2'b00, 4'd1, 16'h6001));
    cyc(1'b1, 16'h0002, 16'h6001);
    expq.push_back(rec(2'b00, 4'd1, 16'h6002));
    cyc(1'b1, 16'h0004, 16'h6002);
    cyc(1'b1, 16'hFFFF, 16'h6003, 1'b1, 1'b1);
    chk("ss_run", {31'd0, running}, 32'd0);
    chk("ss_level", {29'd0, level}, 32'd2);
    cyc(1'b1, 16'h0F0F, 16'h6004);
    chk("ss_idle_level", {29'd0, level}, 32'd2);
    drain();

    // reset mid-run with level=3
    expq.push_back(rec(2'b10, 4'd0, 16'h7000));
    cyc(1'b0, '0, 16'h7000, 1'b1);
    chk("restart_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      expq.push_back(rec(2'b00, 4'd1, 16'h7000 + 16'(i)));
      cyc(1'b1, 16'h0001, 16'h7000 + 16'(i));
    end
    cyc(1'b1, 16'h0001, 16'h7004);
    rd_ready = 1'b1;
    cyc(1'b0, '0, '0);
    rd_ready = 1'b0;
    chk("pre_rst_level", {29'd0, level}, 32'd3);
    chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    reset = 1'b1;
    expq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mrst_level", {29'd0, level}, 32'd0);
    chk("mrst_valid", {31'd0, rd_valid}, 32'd0);
    chk("mrst_run", {31'd0, running}, 32'd0);
    chk("mrst_ovf", {31'd0, overflow}, 32'd0);
`ifdef EDGE_EVENT_DROP_CNT_EN
    chk("mrst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
    expq.push_back(rec(2'b10, 4'd0, 16'h00C3));
    cyc(1'b0, '0, 16'h00C3, 1'b1);
    chk("post_rst_data", {10'd0, rd_data}, {10'd0, rec(2'b10, 4'd0, 16'h00C3)});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
